// File: rtl/if_id_pipe_reg_if.sv
// Valid/ready handshake bundle carrying one PC/instruction pair between pipeline stages.
interface if_id_pipe_reg_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              valid;
    logic              ready;

    modport master (output pc, output inst, output valid, input ready);
    modport slave  (input pc, input inst, input valid, output ready);
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer and branch/jump flush.
// Define IF_ID_PERF_CNT_EN to build the saturating stall/flush performance counters.
module if_id_pipe_reg #(
    parameter int unsigned      DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    if_id_pipe_reg_if.slave      fetch,
    if_id_pipe_reg_if.master     decode,
    input  logic                 flush_i,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] main_pc, main_pc_n;
    logic [DATA_W-1:0] main_inst, main_inst_n;
    logic [DATA_W-1:0] skid_pc, skid_pc_n;
    logic [DATA_W-1:0] skid_inst, skid_inst_n;
    logic              out_valid;

    // ready depends on registered state only, so fetch never sees a path from decode.
    assign fetch.ready  = (state != FULL);
    assign out_valid    = (state != EMPTY);
    assign decode.valid = out_valid;
    assign decode.pc    = main_pc;
    assign decode.inst  = main_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            main_pc   <= '0;
            main_inst <= NOP_INST;
            skid_pc   <= '0;
            skid_inst <= NOP_INST;
        end else begin
            state     <= state_n;
            main_pc   <= main_pc_n;
            main_inst <= main_inst_n;
            skid_pc   <= skid_pc_n;
            skid_inst <= skid_inst_n;
        end
    end

    always_comb begin
        state_n     = state;
        main_pc_n   = main_pc;
        main_inst_n = main_inst;
        skid_pc_n   = skid_pc;
        skid_inst_n = skid_inst;
        if (flush_i) begin
            state_n     = EMPTY;
            main_pc_n   = '0;
            main_inst_n = NOP_INST;
            skid_pc_n   = '0;
            skid_inst_n = NOP_INST;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (fetch.valid) begin
                        main_pc_n   = fetch.pc;
                        main_inst_n = fetch.inst;
                        state_n     = ONE;
                    end
                end
                ONE: begin
                    if (decode.ready) begin
                        if (fetch.valid) begin
                            main_pc_n   = fetch.pc;
                            main_inst_n = fetch.inst;
                        end else begin
                            main_pc_n   = '0;
                            main_inst_n = NOP_INST;
                            state_n     = EMPTY;
                        end
                    end else if (fetch.valid) begin
                        skid_pc_n   = fetch.pc;
                        skid_inst_n = fetch.inst;
                        state_n     = FULL;
                    end
                end
                FULL: begin
                    if (decode.ready) begin
                        main_pc_n   = skid_pc;
                        main_inst_n = skid_inst;
                        state_n     = ONE;
                    end
                end
                default: begin
                    state_n = EMPTY;
                end
            endcase
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !decode.ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_i && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed scenarios plus randomized traffic
// compared against a depth-2 FIFO reference model.
module tb_if_id_pipe_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush_i = 1'b0;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    if_id_pipe_reg_if #(.DATA_W(DATA_W)) f_if ();
    if_id_pipe_reg_if #(.DATA_W(DATA_W)) d_if ();

    if_id_pipe_reg #(
        .DATA_W   (DATA_W),
        .NOP_INST (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (f_if),
        .decode      (d_if),
        .flush_i     (flush_i),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    // Reference: a 2-deep FIFO; accept when it holds fewer than two, present its head.
    item_t            q[$];
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    logic             last_acc = 1'b0;
    int               n_checks = 0;
    int               n_pass = 0;

    function automatic logic m_valid();
        return q.size() > 0;
    endfunction

    function automatic logic m_ready();
        return q.size() < 2;
    endfunction

    function automatic logic [31:0] m_inst();
        return (q.size() > 0) ? q[0].inst : NOP;
    endfunction

    function automatic logic [31:0] m_pc();
        return (q.size() > 0) ? q[0].pc : 32'h0;
    endfunction

    function automatic logic [CNT_W-1:0] exp_stall();
`ifdef IF_ID_PERF_CNT_EN
        return m_stall;
`else
        return '0;
`endif
    endfunction

    function automatic logic [CNT_W-1:0] exp_flush();
`ifdef IF_ID_PERF_CNT_EN
        return m_flush;
`else
        return '0;
`endif
    endfunction

    task automatic drive(input logic vi, input logic [31:0] pc, input logic [31:0] inst,
                         input logic ri, input logic fl);
        f_if.valid = vi;
        f_if.pc    = pc;
        f_if.inst  = inst;
        d_if.ready = ri;
        flush_i    = fl;
    endtask

    // Advance one clock and apply the same edge to the reference model.
    task automatic tick();
        logic cons;
        logic acc;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_stall  = '0;
            m_flush  = '0;
            last_acc = 1'b0;
        end else begin
            cons = m_valid() && d_if.ready;
            acc  = f_if.valid && m_ready();
            if (m_valid() && !d_if.ready && (m_stall != '1)) m_stall = m_stall + 1'b1;
            if (flush_i && (m_flush != '1)) m_flush = m_flush + 1'b1;
            if (flush_i) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back(item_t'{pc: f_if.pc, inst: f_if.inst});
            end
            last_acc = acc;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #100;
        n_checks++; if (d_if.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", d_if.valid); else n_pass++;
        n_checks++; if (f_if.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", f_if.ready); else n_pass++;
        n_checks++; if (d_if.inst !== NOP) $display("FAIL reset_inst: got %h want %h", d_if.inst, NOP); else n_pass++;
        n_checks++; if (d_if.pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", d_if.pc); else n_pass++;
        n_checks++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0)
            $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt_o, flush_cnt_o); else n_pass++;
        #95;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(4 * i), 32'h1111_0001 + 32'(i), 1'b1, 1'b0);
            n_checks++; if (f_if.ready !== 1'b1) $display("FAIL stream_ready: got %b want 1", f_if.ready); else n_pass++;
            tick();
            n_checks++; if (d_if.valid !== 1'b1 || d_if.inst !== 32'h1111_0001 + 32'(i) || d_if.pc !== 32'(4 * i))
                $display("FAIL stream_out[%0d]: got %b %h %h want 1 %h %h", i, d_if.valid, d_if.pc, d_if.inst,
                         32'(4 * i), 32'h1111_0001 + 32'(i));
            else n_pass++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        n_checks++; if (d_if.valid !== 1'b0 || d_if.inst !== NOP)
            $display("FAIL stream_drain: got %b %h want 0 %h", d_if.valid, d_if.inst, NOP); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0]      held;
        logic [CNT_W-1:0] s0;
        int               k;
        logic [31:0]      seen[$];
        s0 = stall_cnt_o;
        drive(1'b1, 32'h100, 32'h2222_0000, 1'b1, 1'b0);
        tick();
        held = d_if.inst;
        k = 1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 32'h2222_0000 + 32'(k), 1'b0, 1'b0);
            tick();
            if (last_acc) k++;
            n_checks++; if (d_if.inst !== held || d_if.valid !== 1'b1)
                $display("FAIL stall_hold[%0d]: got %b %h want 1 %h", c, d_if.valid, d_if.inst, held); else n_pass++;
            n_checks++; if (f_if.ready !== m_ready())
                $display("FAIL stall_ready[%0d]: got %b want %b", c, f_if.ready, m_ready()); else n_pass++;
        end
        n_checks++; if (f_if.ready !== 1'b0) $display("FAIL stall_full_ready: got %b want 0", f_if.ready); else n_pass++;
        n_checks++; if (stall_cnt_o !== exp_stall())
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt_o, exp_stall()); else n_pass++;
`ifdef IF_ID_PERF_CNT_EN
        n_checks++; if (stall_cnt_o - s0 !== CNT_W'(3))
            $display("FAIL stall_cnt_delta: got %0d want 3", stall_cnt_o - s0); else n_pass++;
`endif
        seen.push_back(d_if.inst);
        for (int c = 0; c < 6; c++) begin
            drive(k < 4, 32'h100 + 32'(4 * k), 32'h2222_0000 + 32'(k), 1'b1, 1'b0);
            tick();
            if (last_acc) k++;
            if (d_if.valid === 1'b1) seen.push_back(d_if.inst);
        end
        n_checks++; if (seen.size() != 4)
            $display("FAIL stall_order_count: got %0d want 4", seen.size()); else n_pass++;
        for (int j = 0; j < seen.size() && j < 4; j++) begin
            n_checks++; if (seen[j] !== 32'h2222_0000 + 32'(j))
                $display("FAIL stall_order[%0d]: got %h want %h", j, seen[j], 32'h2222_0000 + 32'(j)); else n_pass++;
        end
    endtask

    task automatic test_flush_full();
        logic [CNT_W-1:0] f0;
        f0 = flush_cnt_o;
        drive(1'b1, 32'h40, 32'hAAAA_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h44, 32'hBBBB_0000, 1'b0, 1'b0);
        tick();
        n_checks++; if (f_if.ready !== 1'b0 || d_if.inst !== 32'hAAAA_0000)
            $display("FAIL flush_full_setup: got %b %h want 0 aaaa0000", f_if.ready, d_if.inst); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        n_checks++; if (d_if.valid !== 1'b0 || d_if.inst !== NOP || d_if.pc !== 32'h0 || f_if.ready !== 1'b1)
            $display("FAIL flush_full_out: got v=%b inst=%h pc=%h rdy=%b want 0 %h 0 1", d_if.valid, d_if.inst,
                     d_if.pc, f_if.ready, NOP);
        else n_pass++;
        n_checks++; if (flush_cnt_o !== exp_flush())
            $display("FAIL flush_cnt: got %0d want %0d", flush_cnt_o, exp_flush()); else n_pass++;
`ifdef IF_ID_PERF_CNT_EN
        n_checks++; if (flush_cnt_o - f0 !== CNT_W'(1))
            $display("FAIL flush_cnt_delta: got %0d want 1", flush_cnt_o - f0); else n_pass++;
`endif
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (d_if.valid !== 1'b0)
                $display("FAIL flush_full_gone[%0d]: got valid=%b inst=%h want 0", c, d_if.valid, d_if.inst); else n_pass++;
        end
    endtask

    task automatic test_flush_input();
        drive(1'b1, 32'h80, 32'hCCCC_0000, 1'b1, 1'b1);
        tick();
        n_checks++; if (d_if.valid !== 1'b0 || d_if.inst !== NOP)
            $display("FAIL flush_in_drop: got %b %h want 0 %h", d_if.valid, d_if.inst, NOP); else n_pass++;
        drive(1'b1, 32'h84, 32'hDDDD_0001, 1'b1, 1'b0);
        tick();
        n_checks++; if (d_if.valid !== 1'b1 || d_if.inst !== 32'hDDDD_0001 || d_if.pc !== 32'h84)
            $display("FAIL flush_in_next: got %b %h %h want 1 84 dddd0001", d_if.valid, d_if.pc, d_if.inst); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'hC0, 32'hEEEE_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hC4, 32'hEEEE_0002, 1'b0, 1'b0);
        tick();
        n_checks++; if (f_if.ready !== 1'b0) $display("FAIL arst_setup: got ready %b want 0", f_if.ready); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (d_if.valid !== 1'b0 || f_if.ready !== 1'b1 || d_if.inst !== NOP)
            $display("FAIL arst_immediate: got v=%b rdy=%b inst=%h want 0 1 %h", d_if.valid, f_if.ready, d_if.inst, NOP);
        else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 32'hC8, 32'hEEEE_0003, 1'b1, 1'b0);
        tick();
        n_checks++; if (d_if.valid !== 1'b1 || d_if.inst !== 32'hEEEE_0003)
            $display("FAIL arst_first_accept: got %b %h want 1 eeee0003", d_if.valid, d_if.inst); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_bubble();
        drive(1'b1, 32'h200, 32'h3333_0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (d_if.valid !== 1'b0 || d_if.inst !== NOP)
                $display("FAIL bubble[%0d]: got %b %h want 0 %h", c, d_if.valid, d_if.inst, NOP); else n_pass++;
        end
        for (int i = 1; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 32'h3333_0000 + 32'(i), 1'b1, 1'b0);
            tick();
            n_checks++; if (d_if.valid !== 1'b1 || d_if.inst !== 32'h3333_0000 + 32'(i))
                $display("FAIL bubble_resume[%0d]: got %b %h want 1 %h", i, d_if.valid, d_if.inst,
                         32'h3333_0000 + 32'(i));
            else n_pass++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
            tick();
            n_checks++;
            if (d_if.valid !== m_valid() || d_if.inst !== m_inst() || f_if.ready !== m_ready() ||
                (m_valid() && d_if.pc !== m_pc())) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: got v=%b pc=%h inst=%h rdy=%b want v=%b pc=%h inst=%h rdy=%b", c,
                             d_if.valid, d_if.pc, d_if.inst, f_if.ready, m_valid(), m_pc(), m_inst(), m_ready());
                errs++;
            end else n_pass++;
        end
        n_checks++; if (stall_cnt_o !== exp_stall())
            $display("FAIL random_stall_cnt: got %0d want %0d", stall_cnt_o, exp_stall()); else n_pass++;
        n_checks++; if (flush_cnt_o !== exp_flush())
            $display("FAIL random_flush_cnt: got %0d want %0d", flush_cnt_o, exp_flush()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_full();
        test_flush_input();
        test_async_reset();
        test_bubble();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Pipeline register between instruction_fetch (upstream) and the decode stage (downstream).
- Captures each fetched instruction and its PC. Carries them to decode with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under decode stalls, with no combinational ready path back into fetch.
- Supports a flush from a taken branch or jump.

Parameters:
- DATA_W, 32, width of instruction and PC.
- NOP_INST, 32'h0000_0000, value driven on inst_o when no valid instruction is held (reset, flush, empty).
- CNT_W, 16, width of optional performance counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- pc_i  input  DATA_W  PC of the instruction from fetch.
- inst_i  input  DATA_W  instruction word from fetch (instruction_output).
- valid_i  input  1  fetch presents a valid instruction.
- ready_o  output  1  block can accept from fetch this cycle.
- flush_i  input  1  discard all held and incoming instructions.
- pc_o  output  DATA_W  PC to decode.
- inst_o  output  DATA_W  instruction to decode.
- valid_o  output  1  pc_o/inst_o valid.
- ready_i  input  1  decode consumes this cycle.
- stall_cnt_o  output  CNT_W  optional feature only.
- flush_cnt_o  output  CNT_W  optional feature only.

Behaviour:

Reset (rst=0, asynchronous):
- State EMPTY; main and skid entries invalid.
- valid_o=0, pc_o=0, inst_o=NOP_INST, ready_o=1.
- Counters=0.

Transfer rules:
- Input transfer: valid_i & ready_o.
- Output transfer: valid_o & ready_i.
- Latency: an accepted instruction appears on pc_o/inst_o with valid_o=1 on the next cycle.

Outputs:
- ready_o = (state != FULL); decoded from registered state only, no dependence on ready_i or valid_i.
- Outputs are driven from the main entry only.

States:
- EMPTY: valid_o=0.
  - valid_i -> load main -> ONE.
  - Otherwise stay EMPTY.
- ONE: main valid.
  - ready_i & valid_i -> main <= input, stay ONE (back-to-back, 1 instr/cycle).
  - ready_i & !valid_i -> EMPTY; inst_o <= NOP_INST.
  - !ready_i & valid_i -> skid <= input -> FULL.
  - !ready_i & !valid_i -> hold.
- FULL: main and skid valid; ready_o=0; valid_i is ignored.
  - ready_i -> main <= skid, skid invalid -> ONE.
  - Otherwise hold.

Flush:
- flush_i=1 has priority over every transition.
- Next state EMPTY; main and skid invalidated; inst_o <= NOP_INST, pc_o <= 0, valid_o=0 next cycle.
- An instruction accepted in the flush cycle is discarded.
- An output transfer in the flush cycle still counts as consumed.

Ordering and integrity:
- Instruction order is preserved.
- No instruction is duplicated or lost except by flush.
- While valid_o=1 and ready_i=0, pc_o/inst_o are stable.

Reset mid-operation:
- Immediate return to reset values regardless of state.
- First accept is possible on the first clk edge after rst rises.

Optional Feature:
IF_ID_PERF_CNT_EN
- Defined:
  - stall_cnt_o increments each cycle with valid_o=1 & ready_i=0.
  - flush_cnt_o increments each cycle flush_i=1.
  - Both saturate at all-ones; both clear on reset.
- Undefined: stall_cnt_o and flush_cnt_o are tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset then stream: hold rst=0 195 ns, then valid_i=1 with inst_i 32'h1111_0001..32'h1111_0005, pc_i 0,4,..,16, ready_i=1 -> inst_o shows the same sequence one cycle later, valid_o=1 every cycle, ready_o=1 throughout.
- Decode stall: during the stream, ready_i=0 for 3 cycles.
  - ready_o drops to 0 the cycle after the skid fills.
  - inst_o holds its value stable.
  - On ready_i=1 the skid word appears next, with no loss or duplication.
  - With the feature on, stall_cnt_o=3.
- Flush in FULL state: main=32'hAAAA_0000, skid=32'hBBBB_0000, flush_i=1 for one cycle -> next cycle valid_o=0, inst_o=NOP_INST, ready_o=1; neither word is ever presented; flush_cnt_o=1.
- Flush with simultaneous input: flush_i=1 and valid_i=1 with inst_i=32'hCCCC_0000 -> 32'hCCCC_0000 is dropped; the next input after flush appears normally.
- Async reset mid-FULL: drive rst=0 between clock edges -> valid_o=0, ready_o=1, inst_o=NOP_INST immediately, without waiting for clk.
- Bubble: valid_i=0 for 2 cycles with ready_i=1 -> valid_o=0 and inst_o=NOP_INST for 2 cycles; the stream then resumes in order.
